// File: rtl/mem_if_pkg.sv
// Shared definitions for the CPU-side memory transaction interface:
// transfer-size codes, responder state encoding and byte-lane helpers.
package mem_if_pkg;

  localparam logic [1:0] RAM_WIDTH8  = 2'd0;
  localparam logic [1:0] RAM_WIDTH16 = 2'd1;
  localparam logic [1:0] RAM_WIDTH32 = 2'd2;
  localparam logic [1:0] RAM_WIDTH64 = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } resp_state_t;

  // Bit 7 is the lane at byte offset 0, i.e. data[63:56] (big-endian).
  localparam logic [7:0] LANE_MASK8  = 8'h80;
  localparam logic [7:0] LANE_MASK16 = 8'hC0;
  localparam logic [7:0] LANE_MASK32 = 8'hF0;
  localparam logic [7:0] LANE_MASK64 = 8'hFF;

  function automatic logic [3:0] width_bytes(input logic [1:0] w);
    return 4'd1 << w;
  endfunction

  function automatic logic [7:0] width_lane_mask(input logic [1:0] w);
    case (w)
      RAM_WIDTH8:  return LANE_MASK8;
      RAM_WIDTH16: return LANE_MASK16;
      RAM_WIDTH32: return LANE_MASK32;
      default:     return LANE_MASK64;
    endcase
  endfunction

  function automatic logic [63:0] expand_mask(input logic [7:0] m);
    logic [63:0] e;
    e = '0;
    for (int b = 0; b < 8; b++) e[8*b +: 8] = {8{m[b]}};
    return e;
  endfunction

endpackage

// File: rtl/mem_lane_mask.sv
// Decodes transfer size and byte offset into a byte-enable mask, an
// alignment flag and the bit shift between MS-aligned data and the word.
module mem_lane_mask
  import mem_if_pkg::*;
(
  input  logic [1:0] width,
  input  logic [2:0] offset,
  output logic [7:0] byte_en,
  output logic       aligned,
  output logic [5:0] shift_bits
);

  assign byte_en    = width_lane_mask(width) >> offset;
  assign shift_bits = {offset, 3'b000};

  always_comb begin
    aligned = 1'b0;
    case (width)
      RAM_WIDTH8:  aligned = 1'b1;
      RAM_WIDTH16: aligned = ~offset[0];
      RAM_WIDTH32: aligned = (offset[1:0] == 2'b00);
      default:     aligned = (offset == 3'b000);
    endcase
  end

endmodule

// File: rtl/mem_responder_bram.sv
// Block-RAM backed responder for the CPU memory transaction interface with
// fixed read/write latency; writes are read-modify-write merged on completion.
module mem_responder_bram
  import mem_if_pkg::*;
#(
  parameter int DEPTH_WORDS = 512,
  parameter int READ_LAT    = 4,
  parameter int WRITE_LAT   = 2
) (
  input  logic        clk_cpu,
  input  logic        rst_n,
  input  logic [27:0] addr,
  input  logic [1:0]  width,
  input  logic [63:0] data_in,
  input  logic        rstrobe,
  input  logic        wstrobe,
  output logic [63:0] data_out,
  output logic        transaction_complete,
  output logic        ready,
  output logic        err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = 16;

  resp_state_t    state_reg, state_next;
  logic [CW-1:0]  cnt_reg, cnt_next;
  logic [AW-1:0]  word_reg;
  logic [1:0]     width_reg;
  logic [7:0]     be_reg;
  logic [5:0]     shift_reg;
  logic [63:0]    wdata_reg;
  logic           is_write_reg;
  logic           ready_reg, tc_reg, err_reg;
  logic [63:0]    data_out_reg;

  logic [7:0]     req_be;
  logic           req_aligned;
  logic [5:0]     req_shift;
  logic           can_take, accept, reject, commit;
  logic [AW-1:0]  rd_idx;
  logic [63:0]    ram_q, be64, merged, rd_aligned;
  logic           unused_addr_bits;

  logic [63:0]    mem [DEPTH_WORDS];

  mem_lane_mask u_lane_mask (
    .width      (width),
    .offset     (addr[2:0]),
    .byte_en    (req_be),
    .aligned    (req_aligned),
    .shift_bits (req_shift)
  );

  assign unused_addr_bits = ^addr[27:3+AW];

  assign can_take = (state_reg == ST_IDLE) && ready_reg;
  assign accept   = can_take && (rstrobe ^ wstrobe) && req_aligned;
  assign reject   = can_take && ((rstrobe & wstrobe) | ((rstrobe ^ wstrobe) & ~req_aligned));
  assign commit   = (state_reg == ST_BUSY) && (cnt_reg == '0);

  // Read port tracks the incoming address while idle so the word is already
  // registered by the time a 1-cycle latency transaction completes.
  assign rd_idx     = (state_reg == ST_IDLE) ? addr[3 +: AW] : word_reg;
  assign be64       = expand_mask(be_reg);
  assign merged     = (ram_q & ~be64) | ((wdata_reg >> shift_reg) & be64);
  assign rd_aligned = (ram_q << shift_reg) & expand_mask(width_lane_mask(width_reg));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next = ST_BUSY;
          cnt_next   = wstrobe ? CW'(WRITE_LAT - 1) : CW'(READ_LAT - 1);
        end
      end
      ST_BUSY: begin
        if (cnt_reg == '0) state_next = ST_DONE;
        else               cnt_next   = cnt_reg - 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_cpu or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      word_reg     <= '0;
      width_reg    <= '0;
      be_reg       <= '0;
      shift_reg    <= '0;
      wdata_reg    <= '0;
      is_write_reg <= 1'b0;
      ready_reg    <= 1'b0;
      tc_reg       <= 1'b0;
      err_reg      <= 1'b0;
      data_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      ready_reg <= (state_next == ST_IDLE);
      tc_reg    <= (state_next == ST_DONE);
      err_reg   <= reject;
      if (accept) begin
        word_reg     <= addr[3 +: AW];
        width_reg    <= width;
        be_reg       <= req_be;
        shift_reg    <= req_shift;
        wdata_reg    <= data_in;
        is_write_reg <= wstrobe;
      end
      if (commit && !is_write_reg) data_out_reg <= rd_aligned;
    end
  end

  // Array has no reset; commit is qualified by the reset-protected state.
  always_ff @(posedge clk_cpu) begin
    if (commit && is_write_reg) mem[word_reg] <= merged;
    ram_q <= mem[rd_idx];
  end

  assign data_out             = data_out_reg;
  assign transaction_complete = tc_reg;
  assign ready                = ready_reg;
  assign err                  = err_reg;

endmodule

// File: tb/tb_mem_responder_bram.sv
// Directed, table-driven check of the BRAM memory responder: latency, lane
// placement, rejections, address wrap, reset abort and busy-strobe ignore.
module tb_mem_responder_bram;

  localparam int DEPTH = 512;
  localparam int RL    = 4;
  localparam int WL    = 2;

  logic        clk_cpu = 1'b0;
  logic        rst_n;
  logic [27:0] addr;
  logic [1:0]  width;
  logic [63:0] data_in;
  logic        rstrobe, wstrobe;
  logic [63:0] data_out;
  logic        transaction_complete, ready, err;

  int checks = 0;
  int errors = 0;

  mem_responder_bram #(.DEPTH_WORDS(DEPTH), .READ_LAT(RL), .WRITE_LAT(WL)) dut (
    .clk_cpu              (clk_cpu),
    .rst_n                (rst_n),
    .addr                 (addr),
    .width                (width),
    .data_in              (data_in),
    .rstrobe              (rstrobe),
    .wstrobe              (wstrobe),
    .data_out             (data_out),
    .transaction_complete (transaction_complete),
    .ready                (ready),
    .err                  (err)
  );

  always #5 clk_cpu = ~clk_cpu;

  typedef struct {
    string       name;
    bit          rd;
    bit          wr;
    logic [1:0]  w;
    logic [27:0] a;
    logic [63:0] d;
    bit          exp_err;
    logic [63:0] exp_dout;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 50) begin
      @(negedge clk_cpu);
      n++;
    end
    check({name, " ready"}, ready, 64'd1);
  endtask

  // Strobe at a negedge, sampled on the next posedge (edge N); sample k counts
  // negedges after edge N, so completion is expected at k == latency.
  task automatic apply(input string name, input bit rd, input bit wr, input logic [1:0] w,
                       input logic [27:0] a, input logic [63:0] d, input bit exp_err,
                       input logic [63:0] exp_dout);
    int  k;
    bit  seen;
    wait_ready(name);
    addr = a; width = w; data_in = d; rstrobe = rd; wstrobe = wr;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    rstrobe = 1'b0; wstrobe = 1'b0;
    check({name, " err"}, err, {63'd0, exp_err});
    if (exp_err) begin
      check({name, " ready_kept"}, ready, 64'd1);
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
        if (transaction_complete) seen = 1'b1;
        @(negedge clk_cpu);
      end
      check({name, " no_complete"}, seen, 64'd0);
      check({name, " data_out"}, data_out, exp_dout);
      k = 0;
    end else begin
      k = 0;
      while (transaction_complete !== 1'b1 && k < 20) begin
        @(negedge clk_cpu);
        k++;
      end
      check({name, " latency"}, 64'(k), 64'(wr ? WL : RL));
      check({name, " data_out"}, data_out, exp_dout);
      @(negedge clk_cpu);
      check({name, " tc_one_cycle"}, transaction_complete, 64'd0);
      check({name, " ready_back"}, ready, 64'd1);
    end
    $display("txn %-10s rd=%0d wr=%0d w=%0d a=%h d=%h err=%0d lat=%0d dout=%h",
             name, rd, wr, w, a, d, exp_err, k, data_out);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int tc_count;
    bit err_seen;

    vecs[0]  = '{"w64",       0, 1, 2'd3, 28'h1010100, 64'h0102030405060708, 0, 64'h0};
    vecs[1]  = '{"r16",       1, 0, 2'd1, 28'h1010100, 64'h0,                0, 64'h0102000000000000};
    vecs[2]  = '{"w8_off3",   0, 1, 2'd0, 28'h1010103, 64'hAA00000000000000, 0, 64'h0102000000000000};
    vecs[3]  = '{"r64",       1, 0, 2'd3, 28'h1010100, 64'h0,                0, 64'h010203AA05060708};
    vecs[4]  = '{"r16_odd",   1, 0, 2'd1, 28'h1010101, 64'h0,                1, 64'h010203AA05060708};
    vecs[5]  = '{"r32_off4",  1, 0, 2'd2, 28'h1010104, 64'h0,                0, 64'h0506070800000000};
    vecs[6]  = '{"w16_off6",  0, 1, 2'd1, 28'h1010106, 64'hBEEF000000000000, 0, 64'h0506070800000000};
    vecs[7]  = '{"r64_b",     1, 0, 2'd3, 28'h1010100, 64'h0,                0, 64'h010203AA0506BEEF};
    vecs[8]  = '{"w32_off2",  0, 1, 2'd2, 28'h1010102, 64'hFFFFFFFF00000000, 1, 64'h010203AA0506BEEF};
    vecs[9]  = '{"r8_off7",   1, 0, 2'd0, 28'h1010107, 64'h0,                0, 64'hEF00000000000000};
    vecs[10] = '{"w_wrap",    0, 1, 2'd3, 28'h0001008, 64'h1122334455667788, 0, 64'hEF00000000000000};
    vecs[11] = '{"r_word1",   1, 0, 2'd3, 28'h0000008, 64'h0,                0, 64'h1122334455667788};

    rst_n = 1'b0; addr = '0; width = '0; data_in = '0; rstrobe = 1'b0; wstrobe = 1'b0;
    repeat (3) @(negedge clk_cpu);
    check("rst ready", ready, 64'd0);
    check("rst tc", transaction_complete, 64'd0);
    check("rst err", err, 64'd0);
    check("rst data_out", data_out, 64'd0);
    rst_n = 1'b1;
    #1 check("rel ready_low", ready, 64'd0);
    @(negedge clk_cpu);
    check("rel ready_high", ready, 64'd1);
    check("rel tc", transaction_complete, 64'd0);

    for (int i = 0; i < 12; i++)
      apply(vecs[i].name, vecs[i].rd, vecs[i].wr, vecs[i].w, vecs[i].a, vecs[i].d,
            vecs[i].exp_err, vecs[i].exp_dout);

    // Simultaneous strobes must be rejected without touching the array.
    apply("both", 1, 1, 2'd3, 28'h1010100, 64'h0, 1, 64'h1122334455667788);
    apply("r_after_both", 1, 0, 2'd3, 28'h1010100, 64'h0, 0, 64'h010203AA0506BEEF);

    // Reset while a write is in flight: nothing committed, no completion.
    wait_ready("rst_mid");
    addr = 28'h1010100; width = 2'd3; data_in = 64'hDEADBEEFCAFEF00D; wstrobe = 1'b1;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    wstrobe = 1'b0;
    rst_n = 1'b0;
    #1;
    check("rst_mid ready", ready, 64'd0);
    check("rst_mid tc", transaction_complete, 64'd0);
    check("rst_mid data_out", data_out, 64'd0);
    tc_count = 0;
    repeat (3) begin
      @(negedge clk_cpu);
      if (transaction_complete) tc_count++;
    end
    check("rst_mid no_complete", 64'(tc_count), 64'd0);
    rst_n = 1'b1;
    @(negedge clk_cpu);
    check("rst_mid ready_after", ready, 64'd1);
    $display("txn %-10s write aborted by reset", "rst_mid");
    apply("r_after_rst", 1, 0, 2'd3, 28'h1010100, 64'h0, 0, 64'h010203AA0506BEEF);

    // A write strobe during BUSY is dropped: one completion, no err.
    wait_ready("busy_ign");
    addr = 28'h0000008; width = 2'd3; data_in = 64'h5555AAAA5555AAAA; wstrobe = 1'b1;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    addr = 28'h1010100; data_in = 64'h0; wstrobe = 1'b1;
    tc_count = 0;
    err_seen = 1'b0;
    @(posedge clk_cpu);
    @(negedge clk_cpu);
    wstrobe = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (transaction_complete) tc_count++;
      if (err) err_seen = 1'b1;
      @(negedge clk_cpu);
    end
    check("busy_ign tc_count", 64'(tc_count), 64'd1);
    check("busy_ign no_err", err_seen, 64'd0);
    $display("txn %-10s completions=%0d", "busy_ign", tc_count);
    apply("r_ign_tgt", 1, 0, 2'd3, 28'h1010100, 64'h0, 0, 64'h010203AA0506BEEF);
    apply("r_busy_wr", 1, 0, 2'd3, 28'h0000008, 64'h0, 0, 64'h5555AAAA5555AAAA);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_responder_bram.md
Name: mem_responder_bram

Overview:
On-chip responder for the CPU-side memory transaction interface (addr/width/data/rstrobe/wstrobe/ready/transaction_complete) that the traffic generator drives. It plugs in where the DDR2 controller wrapper sits and services reads and writes from a block-RAM array with a programmable, deterministic latency. Its uses are initiator bring-up without DDR2, simulation speed-up, and a scratchpad.

Parameters:
DEPTH_WORDS, 512, number of 64-bit words in the array (power of 2)
READ_LAT, 4, cycles from strobe acceptance to transaction_complete for reads (>=1)
WRITE_LAT, 2, cycles from strobe acceptance to transaction_complete for writes (>=1)

Ports:
clk_cpu  in  1  clock
rst_n  in  1  reset: asynchronous, active-low; clock clk_cpu
addr  in  28  byte address
width  in  2  transfer size: 0=8b, 1=16b, 2=32b, 3=64b
data_in  in  64  write data, MS-byte aligned
rstrobe  in  1  read request, 1-cycle pulse
wstrobe  in  1  write request, 1-cycle pulse
data_out  out  64  read data, MS-byte aligned
transaction_complete  out  1  1-cycle done pulse
ready  out  1  able to accept a strobe
err  out  1  1-cycle pulse on a rejected request

Behaviour:
- Reset (async assert): data_out=0, transaction_complete=0, ready=0, err=0, state=IDLE. The array is not cleared.
- ready rises on the first clk_cpu edge after rst_n deasserts.
- Byte order is big-endian: byte addr+k maps to data[63-8k -: 8].
- A narrow transfer of n bytes uses data[63 -: 8n].
- For narrow reads, data_out lower bytes are 0.
- Word index = addr[3+log2(DEPTH_WORDS)-1:3]. Upper address bits are ignored, so accesses wrap modulo the array size.
- Byte offset = addr[2:0]. The offset must be a multiple of the transfer size (8b: any; 16b: even; 32b: 0 or 4; 64b: 0).
- States:
  - IDLE: ready=1. On an edge with rstrobe^wstrobe and the request legal, latch addr/width/data_in/direction, load the counter with LAT-1, go to BUSY, and drop ready.
  - BUSY: ready=0. The counter decrements each cycle; at 0, go to DONE.
  - DONE: transaction_complete=1 for exactly one cycle, ready=0. Then go to IDLE (ready=1 the following cycle).
- Latency: with a strobe sampled at edge N, transaction_complete is high in the cycle after edge N+LAT.
- Writes: a read-modify-write merge using the byte-enable mask is committed to the array on the DONE transition only.
- Reads:
  - data_out updates on entry to DONE and is valid in the transaction_complete cycle.
  - data_out holds until the next read completes; writes do not alter it.
- Rejections:
  - Simultaneous rstrobe and wstrobe in IDLE: no access, err pulses 1 cycle, state stays IDLE, ready stays 1.
  - Misaligned request in IDLE: same as simultaneous strobes (err pulse, no access, no transaction_complete).
- Strobes while ready=0 are ignored silently: no err, no queueing.
- Reset mid-operation: the transaction is aborted, an uncommitted write leaves the array unchanged, and no transaction_complete is issued.
- A read after a write to the same address always returns the written data; there is no forwarding hazard because the write commits before ready returns.

Decomposition:
- Shared package mem_if_pkg:
  - RAM_WIDTH8/16/32/64 constants (0..3).
  - Responder state encoding.
  - A bytes-per-width function.
  - Lane-mask constants.
- Sub-module mem_lane_mask (combinational): width + addr[2:0] → 8-bit byte-enable, aligned flag, and lane-shift amount.
- The array is inferred inside the top module as simple-dual-port BRAM with a 1-cycle read.

Test Plan:
- Reset release → ready=0 during reset; ready=1 one edge after rst_n rises; data_out=0; no transaction_complete.
- 64b write of 0x0102030405060708 to 0x1010100, then 16b read at 0x1010100 → complete WRITE_LAT then READ_LAT cycles after each strobe; data_out=0x0102000000000000.
- 8b write of 0xAA (data_in=0xAA00000000000000) at 0x1010103 over the word above, then 64b read → data_out=0x010203AA05060708.
- 16b read at odd addr 0x1010101 → err pulse in the cycle after the strobe; ready stays 1; no transaction_complete; data_out unchanged.
- rstrobe and wstrobe together → err pulse, no array change.
- Wrap check: write at word DEPTH_WORDS+1, read word 1 → same data.
- Write strobe, then rst_n low in BUSY, then release, then read the same address → the old contents are returned.
- wstrobe issued while BUSY → ignored; exactly one transaction_complete occurs.
